// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: operation encodings, MDU FSM states and constants.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/rv32m_mdu_iter_core.sv
// mdu_iter_core: unsigned magnitude datapath for the RV32M unit.
// Runs a 64-bit shift-add multiply and a restoring divide side by side,
// one bit per enabled step; the caller picks the result it needs.
module mdu_iter_core #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    output logic        o_last,
    output logic [63:0] o_prod,
    output logic [31:0] o_quo,
    output logic [31:0] o_rem
);

    logic [4:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [32:0] r_mplier;
    logic [63:0] r_prod;
    logic [32:0] r_div;
    logic [31:0] r_q;
    logic [32:0] r_rem;

    logic [33:0] w_rem_sh;
    logic [33:0] w_diff;
    logic        w_ge;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign w_rem_sh = {r_rem, r_q[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_div};
    assign w_ge     = ~w_diff[33];

    assign o_last = (r_cnt == 5'(ITER - 1));
    assign o_prod = r_prod;
    assign o_quo  = r_q;
    assign o_rem  = r_rem[31:0];

    // Iteration counter: cleared on reset or a new load, wraps after the last step.
    always_ff @(posedge clk) begin
        if (reset || i_load) begin
            r_cnt <= 5'd0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 5'd1;
        end
    end

    // Multiply and divide bit-serial datapath.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_mcand  <= {31'd0, i_a};
            r_mplier <= i_b;
            r_prod   <= 64'd0;
            r_div    <= i_b;
            r_q      <= i_a[31:0];
            r_rem    <= 33'd0;
        end else if (i_step) begin
            r_prod   <= r_prod + (r_mplier[0] ? r_mcand : 64'd0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_rem    <= w_ge ? w_diff[32:0] : w_rem_sh[32:0];
            r_q      <= {r_q[30:0], w_ge};
        end
    end

endmodule

// File: rtl/rv32m_mdu.sv
// rv32m_mdu: iterative RV32M multiply/divide unit feeding the write-back mux.
// Holds the FSM, operand sign handling, divide special cases and the
// registered outputs; the bit-serial datapath lives in mdu_iter_core.
// Optional feature macro: RV32M_MDU_FAST_MUL_EN (single-cycle multiplies).
module rv32m_mdu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    mdu_state_e r_state;
    mdu_op_e    r_op;
    logic [4:0]  r_rd;
    logic [32:0] r_mag_a;
    logic [32:0] r_mag_b;
    logic        r_neg;
    logic        r_sa;
    logic        r_special;
    logic [31:0] r_spec_res;
    logic        r_busy;
    logic        r_done;
    logic        r_reg_write;
    logic [31:0] r_result;
    logic [4:0]  r_rd_out;

    logic        w_is_div;
    logic        w_a_sgn;
    logic        w_b_sgn;
    logic        w_sa;
    logic        w_sb;
    logic [32:0] w_mag_a;
    logic [32:0] w_mag_b;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic [31:0] w_spec_res;
    logic        w_accept;
    logic        w_last;
    logic [63:0] w_prod_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_prod;
    logic [31:0] w_calc_res;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_is_div = funct3[2];
    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM, rs2 for MUL/MULH/DIV/REM.
    assign w_a_sgn  = (funct3 == OP_MUL) || (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                      (funct3 == OP_DIV) || (funct3 == OP_REM);
    assign w_b_sgn  = (funct3 == OP_MUL) || (funct3 == OP_MULH) ||
                      (funct3 == OP_DIV) || (funct3 == OP_REM);
    assign w_sa     = w_a_sgn && rs1_data[31];
    assign w_sb     = w_b_sgn && rs2_data[31];
    // 33-bit magnitudes so that -2^31 is representable.
    assign w_mag_a  = w_sa ? (33'd0 - {1'b1, rs1_data}) : {1'b0, rs1_data};
    assign w_mag_b  = w_sb ? (33'd0 - {1'b1, rs2_data}) : {1'b0, rs2_data};

    assign w_div_zero = w_is_div && (rs2_data == 32'd0);
    assign w_div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                        (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign w_spec_res = w_div_zero ? (funct3[1] ? rs1_data : DIV_BY_ZERO_Q)
                                   : (funct3[1] ? 32'd0 : 32'h8000_0000);

    mdu_iter_core #(
        .ITER (ITER)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_step (r_state == S_CALC),
        .i_a    (w_mag_a),
        .i_b    (w_mag_b),
        .o_last (w_last),
        .o_prod (w_prod_mag),
        .o_quo  (w_quo),
        .o_rem  (w_rem)
    );

`ifdef RV32M_MDU_FAST_MUL_EN
    logic signed [32:0] r_xa;
    logic signed [32:0] r_xb;
    logic signed [65:0] w_fast;

    // Sign/zero-extended operands for the single-cycle multiplier.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xa <= {w_a_sgn & rs1_data[31], rs1_data};
            r_xb <= {w_b_sgn & rs2_data[31], rs2_data};
        end
    end

    assign w_fast = 66'(r_xa) * 66'(r_xb);
    assign w_prod = w_fast[63:0];
`else
    assign w_prod = r_neg ? (64'd0 - w_prod_mag) : w_prod_mag;
`endif

    // Final sign fixup and result selection for the latched operation.
    always_comb begin
        w_calc_res = 32'd0;
        case (r_op)
            OP_MUL:                       w_calc_res = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[63:32];
            OP_DIV, OP_DIVU:              w_calc_res = r_neg ? (32'd0 - w_quo) : w_quo;
            default:                      w_calc_res = r_sa ? (32'd0 - w_rem) : w_rem;
        endcase
    end

    // Latch the operation context when a request is accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op       <= mdu_op_e'(funct3);
            r_rd       <= rd_in;
            r_mag_a    <= w_mag_a;
            r_mag_b    <= w_mag_b;
            r_neg      <= w_sa ^ w_sb;
            r_sa       <= w_sa;
            r_special  <= w_special;
            r_spec_res <= w_spec_res;
        end
    end

    // Control FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            r_result    <= 32'd0;
            r_rd_out    <= 5'd0;
        end else begin
            r_done      <= 1'b0;
            r_reg_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= start;
                    if (start) begin
                        if (w_special) begin
                            r_state <= S_FINISH;
`ifdef RV32M_MDU_FAST_MUL_EN
                        end else if (!w_is_div) begin
                            r_state <= S_FINISH;
`endif
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (w_last) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_result    <= r_special ? r_spec_res : w_calc_res;
                    r_rd_out    <= r_rd;
                    r_done      <= 1'b1;
                    r_reg_write <= (r_rd != 5'd0);
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign rd_out    = r_rd_out;
    assign reg_write = r_reg_write;

    // Magnitude copies are kept for debug visibility of the accepted operands.
    logic w_unused;
    assign w_unused = ^{r_mag_a, r_mag_b};

endmodule
